mux8_arbiter: RTL
=================

# mux8_arbiter

Round-robin arbiter that shares one 8-input mux-selected resource (memory port, ALU operand bus) among eight requesters in the multicycle CPU datapath. It samples request lines and grants exactly one owner at a time. It drives the 3-bit select of the shared 8:1 mux and holds the grant until the resource signals completion, the owner withdraws, or a timeout expires. It sits between the control unit's requesting sub-blocks and the shared mux.

## Interface
- TIMEOUT, 16: max GRANT cycles before forced release; legal 2..31.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  8  request per requester; level, held until served or abandoned.
- done  in  1  single-cycle completion pulse from shared resource.
- sel  out  3  mux select = index of current/last owner.
- gnt  out  8  one-hot grant; all-zero when idle.
- busy  out  1  high while in GRANT.
- timeout  out  1  single-cycle pulse on forced release.

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: sel=0, gnt=0, busy=0, timeout=0, ptr=0, cnt=0, state=IDLE.
- Two states:
  - IDLE: if req≠0 at an edge, choose the winner by scanning indices ptr, ptr+1, …, ptr+7 (mod 8); first set bit wins. Register owner, sel=owner, gnt=1<<owner, busy=1, cnt=0, go to GRANT. If req=0, stay; sel keeps last value, gnt=0.
  - GRANT, evaluated at each edge in this priority order:
    - done=1 → release.
    - req[owner]=0 (abandon) → release, no timeout.
    - cnt==TIMEOUT-1 → release, timeout=1 for one cycle.
    - otherwise cnt+=1.
- Release: gnt=0, busy=0, ptr=(owner+1) mod 8 (3-bit wrap), state=IDLE; sel unchanged.
- done in IDLE is ignored. req changes of non-owners during GRANT have no effect.
- done and timeout in the same cycle: done wins, no timeout pulse.
- cnt is 5 bits; never exceeds TIMEOUT-1.
- Reset mid-GRANT: outputs drop to reset values asynchronously; no timeout pulse; priority restarts at req[0].

## Timing
- Grant latency: req sampled at edge k in IDLE → gnt/sel/busy valid after edge k.
- Release latency: done sampled at edge m → gnt=0 after edge m.
- Minimum gap between grants: one idle cycle (next grant earliest after edge m+1).
- Max hold: TIMEOUT cycles of gnt high, then forced release; timeout high exactly one cycle, coincident with the first gnt=0 cycle.
- sel changes only on a new grant (or reset), so the mux output is stable throughout a grant.
- All outputs are registered; no combinational path from req/done to outputs.

## Structure
- Shared package (cpu_ctrl_pkg): state encodings ST_IDLE/ST_GRANT, NREQ=8, SEL_W=3, CNT_W=5.
- Sub-module rr_pick8: combinational rotate-priority picker; inputs req[7:0], ptr[2:0]; outputs found, idx[2:0]. Instantiated once in IDLE decode.
- Top holds the FSM, owner/ptr/cnt registers and output registers.

## Test plan
- Reset then req=8'b0000_0001 → after the next edge gnt=0x01, sel=0, busy=1; done pulse → gnt=0 next cycle, ptr=1.
- req=0xFF held, done pulsed every grant → grant order 0,1,2,…,7,0 with one idle cycle between grants; sel tracks the index.
- ptr=6, req=8'b0100_0001 → grant to 6 (sel=6), then to 0 after release (wrap-around).
- TIMEOUT=4, req[3] held, no done → gnt=0x08 for exactly 4 cycles, then gnt=0 with a one-cycle timeout pulse; done on the final cycle instead → no pulse.
- Owner drops req[2] mid-grant → release next edge, timeout=0, ptr=3.
- Assert reset during GRANT with cnt=2 → gnt=0, sel=0, busy=0 immediately (before the clock edge); next grant priority starts at req[0].

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types for the shared-resource arbiter and its picker.
// Pure declarations; no logic, no latency, no flow control.
package cpu_ctrl_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod 8.
// Purely combinational, zero latency; no backpressure.
// Requesters only raise levels; holding or dropping them is the arbiter's concern.
module rr_pick8
    import cpu_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the closest-to-ptr hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 mux; holds grant until done, abandon or timeout.
// Latency: grant one edge after req seen in IDLE, release one edge after done/abandon/timeout.
// Backpressure: losers hold req level; at least one idle cycle separates successive grants.
module mux8_arbiter
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic             busy_q,  busy_d;
    logic             tout_q,  tout_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             at_limit;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req = req[owner_q];
    assign at_limit  = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        tout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // done outranks abandon, which outranks the forced release.
                if (done || !owner_req || at_limit) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = owner_q + 1'b1;
                    tout_d  = !done && owner_req && at_limit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // sel is the owner register itself, so it only moves on a new grant or reset.
    assign sel     = owner_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = tout_q;

endmodule
